// File: rtl/conv_pkg.sv
// Shared types for the convolution weight scheduler: FSM state encoding,
// loader lane count and the per-group valid-lane mask helper.
package conv_pkg;

    localparam int CONV_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_REQ  = 3'd1,
        ST_LOAD_WAIT = 3'd2,
        ST_COMP_REQ  = 3'd3,
        ST_COMP_WAIT = 3'd4,
        ST_DONE      = 3'd5
    } sched_state_e;

    // Only the final group can be partial; K%4 tells how many filters it holds.
    function automatic logic [CONV_LANES-1:0] lane_mask_f(input logic [1:0] k_rem,
                                                          input logic       last_grp);
        logic [CONV_LANES-1:0] m;
        m = 4'b1111;
        if (last_grp) begin
            case (k_rem)
                2'd1:    m = 4'b0001;
                2'd2:    m = 4'b0011;
                2'd3:    m = 4'b0111;
                default: m = 4'b1111;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/conv_loop_cnt.sv
// Two-level loop counter: c (input channel) inner, g (filter group) outer.
// Exposes flags for the position the counter is about to hold.
module conv_loop_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 adv,
    input  logic [CNT_WIDTH-1:0] lim_c,
    input  logic [CNT_WIDTH:0]   lim_g,
    output logic [CNT_WIDTH-1:0] g_nxt,
    output logic                 first_nxt,
    output logic                 last_nxt,
    output logic                 last_grp_nxt,
    output logic                 at_end
);
    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   ONE_G = (CNT_WIDTH+1)'(1);

    logic [CNT_WIDTH-1:0] c_q, c_d, g_q, g_d, lim_c_q, lim_c_d;
    logic [CNT_WIDTH:0]   lim_g_q, lim_g_d;
    logic                 last_c, last_g;

    always_comb begin
        lim_c_d = lim_c_q;
        lim_g_d = lim_g_q;
        c_d     = c_q;
        g_d     = g_q;
        last_c  = (c_q == lim_c_q - ONE_C);
        last_g  = ({1'b0, g_q} == lim_g_q - ONE_G);
        if (load) begin
            lim_c_d = lim_c;
            lim_g_d = lim_g;
            c_d     = '0;
            g_d     = '0;
        end else if (adv) begin
            if (!last_c) begin
                c_d = c_q + ONE_C;
            end else if (!last_g) begin
                c_d = '0;
                g_d = g_q + ONE_C;
            end
        end
        g_nxt        = g_d;
        first_nxt    = (c_d == '0);
        last_nxt     = (c_d == lim_c_d - ONE_C);
        last_grp_nxt = ({1'b0, g_d} == lim_g_d - ONE_G);
        at_end       = last_c && last_g;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q     <= '0;
            g_q     <= '0;
            lim_c_q <= '0;
            lim_g_q <= '0;
        end else begin
            c_q     <= c_d;
            g_q     <= g_d;
            lim_c_q <= lim_c_d;
            lim_g_q <= lim_g_d;
        end
    end

endmodule

// File: rtl/conv_weight_sched.sv
// Layer sequencer: per (g,c) step, start a 4-lane weight load, then a MAC pass.
// Build option CONV_SCHED_PERF_EN adds the saturating busy-cycle counter cycle_cnt.
module conv_weight_sched
    import conv_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int LANES     = CONV_LANES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [CNT_WIDTH-1:0] cfg_in_ch,
    input  logic [CNT_WIDTH-1:0] cfg_out_ch,
    output logic                 busy,
    output logic                 done,
    output logic                 wl_start,
    input  logic                 wl_end,
    output logic                 comp_start,
    input  logic                 comp_done,
    output logic                 comp_first,
    output logic                 comp_last,
    output logic [CNT_WIDTH-1:0] comp_group,
    output logic [LANES-1:0]     lane_mask
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]          cycle_cnt
`endif
);
    // state        | meaning
    // ST_IDLE      | waiting for cfg_start
    // ST_LOAD_REQ  | wl_start pulse for current (g,c)
    // ST_LOAD_WAIT | waiting for a fresh rising edge of wl_end
    // ST_COMP_REQ  | comp_start pulse
    // ST_COMP_WAIT | waiting for comp_done, then advance c/g
    // ST_DONE      | done pulse, back to idle

    sched_state_e         state_q, state_d;
    logic                 wl_end_prev_q, wl_end_prev_d;
    logic [1:0]           k_rem_q, k_rem_d;
    logic                 comp_first_q, comp_first_d, comp_last_q, comp_last_d;
    logic [CNT_WIDTH-1:0] comp_group_q, comp_group_d;
    logic [LANES-1:0]     lane_mask_q, lane_mask_d;
    logic                 cnt_load, cnt_adv, wl_rise;
    logic                 nxt_first, nxt_last, nxt_last_grp, at_end;
    logic [CNT_WIDTH-1:0] nxt_g;
    logic [CNT_WIDTH:0]   grp_cnt;

    // One extra bit so K near full scale cannot overflow the group count.
    assign grp_cnt = ({1'b0, cfg_out_ch} + (CNT_WIDTH+1)'(3)) >> 2;
    assign wl_rise = wl_end && !wl_end_prev_q;

    conv_loop_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_loop (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (cnt_load),
        .adv          (cnt_adv),
        .lim_c        (cfg_in_ch),
        .lim_g        (grp_cnt),
        .g_nxt        (nxt_g),
        .first_nxt    (nxt_first),
        .last_nxt     (nxt_last),
        .last_grp_nxt (nxt_last_grp),
        .at_end       (at_end)
    );

    always_comb begin
        state_d       = state_q;
        k_rem_d       = k_rem_q;
        wl_end_prev_d = wl_end;
        cnt_load      = 1'b0;
        cnt_adv       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    k_rem_d = cfg_out_ch[1:0];
                    if (cfg_in_ch == '0 || cfg_out_ch == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = ST_LOAD_REQ;
                    end
                end
            end
            ST_LOAD_REQ:  state_d = ST_LOAD_WAIT;
            ST_LOAD_WAIT: if (wl_rise) state_d = ST_COMP_REQ;
            ST_COMP_REQ:  state_d = ST_COMP_WAIT;
            ST_COMP_WAIT: begin
                if (comp_done) begin
                    if (at_end) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_adv = 1'b1;
                        state_d = ST_LOAD_REQ;
                    end
                end
            end
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Step descriptors change only when a new step begins, so they hold through compute.
    always_comb begin
        comp_first_d = comp_first_q;
        comp_last_d  = comp_last_q;
        comp_group_d = comp_group_q;
        lane_mask_d  = lane_mask_q;
        if (state_d == ST_LOAD_REQ && state_q != ST_LOAD_REQ) begin
            comp_first_d = nxt_first;
            comp_last_d  = nxt_last;
            comp_group_d = nxt_g;
            lane_mask_d  = lane_mask_f(k_rem_d, nxt_last_grp);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wl_end_prev_q <= 1'b0;
            k_rem_q       <= '0;
            comp_first_q  <= 1'b0;
            comp_last_q   <= 1'b0;
            comp_group_q  <= '0;
            lane_mask_q   <= '0;
        end else begin
            state_q       <= state_d;
            wl_end_prev_q <= wl_end_prev_d;
            k_rem_q       <= k_rem_d;
            comp_first_q  <= comp_first_d;
            comp_last_q   <= comp_last_d;
            comp_group_q  <= comp_group_d;
            lane_mask_q   <= lane_mask_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign wl_start   = (state_q == ST_LOAD_REQ);
    assign comp_start = (state_q == ST_COMP_REQ);
    assign comp_first = comp_first_q;
    assign comp_last  = comp_last_q;
    assign comp_group = comp_group_q;
    assign lane_mask  = lane_mask_q;

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (state_q == ST_IDLE && cfg_start) begin
            cycle_cnt_d = '0;
        end else if (busy && cycle_cnt_q != 32'hFFFF_FFFF) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule
